biquad_driver: RTL and testbench

//  Initiator/sequencer for the equalizer biquad filter stage. Accepts one float32 audio sample per

---
 rtl/equalizer_pkg.sv | 6 +
 rtl/sample_history.sv | 31 +++
 rtl/biquad_driver.sv | 89 ++++++++
 tb/tb_biquad_driver.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/equalizer_pkg.sv
// equalizer_pkg: shared float32 type, driver FSM states and constants for the equalizer stage
package equalizer_pkg;
  typedef logic [31:0] float32_t;
  typedef enum logic [2:0] {IDLE, WAIT, FIRE, CAPT, HOLD} drv_state_e;
  localparam float32_t FLOAT_ZERO = 32'h0000_0000;
endpackage

// File: rtl/sample_history.sv
// sample_history: three-deep float32 sample shift register with synchronous clear
module sample_history
  import equalizer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_shift_en,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_x0,
  output logic [DATA_W-1:0] o_x1,
  output logic [DATA_W-1:0] o_x2
);
  logic [DATA_W-1:0] x0_q, x1_q, x2_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      x0_q <= DATA_W'(FLOAT_ZERO);
      x1_q <= DATA_W'(FLOAT_ZERO);
      x2_q <= DATA_W'(FLOAT_ZERO);
    end else if (i_shift_en) begin
      x2_q <= x1_q;
      x1_q <= x0_q;
      x0_q <= i_d;
    end
  end
  assign o_x0 = x0_q;
  assign o_x1 = x1_q;
  assign o_x2 = x2_q;
endmodule

// File: rtl/biquad_driver.sv
// biquad_driver: sample sequencer for one biquad band; waits out the filter pipeline, strobes o_start, returns y0.
// BIQUAD_DRV_BYPASS_EN adds i_bypass, which returns the raw sample without strobing the filter.
module biquad_driver
  import equalizer_pkg::*;
#(
  parameter int WAIT_CYCLES = 16,
  parameter int DATA_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_flush,
`ifdef BIQUAD_DRV_BYPASS_EN
  input  logic              i_bypass,
`endif
  output logic [DATA_W-1:0] o_x0,
  output logic [DATA_W-1:0] o_x1,
  output logic [DATA_W-1:0] o_x2,
  output logic              o_start,
  input  logic [DATA_W-1:0] i_y0,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy
);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  drv_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              start_q, valid_q, byp_q, byp, accept, flush;
  logic [DATA_W-1:0] data_q;
`ifdef BIQUAD_DRV_BYPASS_EN
  assign byp = i_bypass;
`else
  assign byp = 1'b0;
`endif
  assign o_in_ready = state_q == IDLE && !i_flush;
  assign accept     = i_in_valid && o_in_ready;
  assign flush      = state_q == IDLE && i_flush;
  sample_history #(.DATA_W(DATA_W)) u_hist (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_shift_en (accept),
    .i_clear    (flush),
    .i_d        (i_in_data),
    .o_x0       (o_x0),
    .o_x1       (o_x1),
    .o_x2       (o_x2)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      byp_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          byp_q   <= byp;
          cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
          state_q <= byp ? CAPT : WAIT;
        end
        WAIT: if (cnt_q == '0) begin
          start_q <= 1'b1;
          state_q <= FIRE;
        end else cnt_q <= cnt_q - CNT_W'(1);
        FIRE: state_q <= CAPT;
        CAPT: begin
          data_q  <= byp_q ? o_x0 : i_y0;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: if (i_out_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_start     = start_q;
  assign o_out_valid = valid_q;
  assign o_out_data  = data_q;
  assign o_busy      = state_q != IDLE;
endmodule

// File: tb/tb_biquad_driver.sv
// tb_biquad_driver: scoreboard bench; the filter model negates x0 into y0 on each o_start.
module tb_biquad_driver;
  localparam int W = 16;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_in_valid = 1'b0, i_flush = 1'b0, i_out_ready = 1'b1, bypass = 1'b0;
  logic [31:0] i_in_data = '0, i_y0, o_x0, o_x1, o_x2, o_out_data;
  logic        o_in_ready, o_start, o_out_valid, o_busy;
  logic [31:0] sb[$];
  int          tests = 0, fails = 0;

  biquad_driver #(.WAIT_CYCLES(W), .DATA_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_flush     (i_flush),
`ifdef BIQUAD_DRV_BYPASS_EN
    .i_bypass    (bypass),
`endif
    .o_x0        (o_x0),
    .o_x1        (o_x1),
    .o_x2        (o_x2),
    .o_start     (o_start),
    .i_y0        (i_y0),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk)
    if (!i_rst_n) i_y0 <= 32'h0;
    else if (o_start) i_y0 <= o_x0 ^ 32'h8000_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge i_clk)
    if (i_rst_n && o_out_valid && i_out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %h expected no result", o_out_data);
      end else check("out_data", o_out_data, sb.pop_front());
    end

  task automatic run(input logic [31:0] d, input logic b, input int st_n, input int v_n, input int hold, input logic [31:0] exp);
    int sn = 0, vn = 0, sc = 0;
    logic [31:0] held;
    @(negedge i_clk);
    i_in_valid = 1'b1; i_in_data = d; bypass = b; i_out_ready = (hold == 0);
    sb.push_back(exp);
    @(posedge i_clk); #1 i_in_valid = 1'b0;
    for (int n = 1; n <= 40 && vn == 0; n++) begin
      @(negedge i_clk);
      if (n == 1) check("busy", {31'b0, o_busy}, 32'd1);
      if (o_start) begin sc++; if (sn == 0) sn = n; end
      if (o_out_valid) vn = n;
    end
    held = o_out_data;
    for (int h = 0; h < hold && vn != 0; h++) begin
      @(negedge i_clk);
      check("hold_valid", {31'b0, o_out_valid}, 32'd1);
      check("hold_data", o_out_data, held);
      check("hold_in_ready", {31'b0, o_in_ready}, 32'd0);
      check("hold_start", {31'b0, o_start}, 32'd0);
    end
    if (hold > 0) begin
      @(posedge i_clk); #1 i_out_ready = 1'b1;
      @(negedge i_clk);
    end
    @(posedge i_clk); #1;
    check("start_count", sc, b ? 0 : 1);
    if (!b) check("start_cycle", sn, st_n);
    check("valid_cycle", vn, v_n);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_x0", o_x0, 32'h0);
    check("rst_x1", o_x1, 32'h0);
    check("rst_x2", o_x2, 32'h0);
    check("rst_out", {o_out_valid, o_start, o_busy, o_in_ready}, 4'b0001);
    check("rst_data", o_out_data, 32'h0);

    run(32'h3F80_0000, 1'b0, W + 1, W + 3, 0, 32'hBF80_0000);
    run(32'h4000_0000, 1'b0, W + 1, W + 3, 0, 32'hC000_0000);
    run(32'h4040_0000, 1'b0, W + 1, W + 3, 5, 32'hC040_0000);
    check("hist_x0", o_x0, 32'h4040_0000);
    check("hist_x1", o_x1, 32'h4000_0000);
    check("hist_x2", o_x2, 32'h3F80_0000);

    @(negedge i_clk);
    i_flush = 1'b1; i_in_valid = 1'b1; i_in_data = 32'hDEAD_BEEF;
    #1 check("flush_in_ready", {31'b0, o_in_ready}, 32'd0);
    @(posedge i_clk); #1 i_flush = 1'b0; i_in_valid = 1'b0;
    @(negedge i_clk);
    check("flush_x0", o_x0, 32'h0);
    check("flush_x1", o_x1, 32'h0);
    check("flush_x2", o_x2, 32'h0);
    check("flush_busy", {31'b0, o_busy}, 32'd0);

    run(32'h3F80_0000, 1'b0, W + 1, W + 3, 0, 32'hBF80_0000);
    check("post_flush_x0", o_x0, 32'h3F80_0000);
    check("post_flush_x1", o_x1, 32'h0);

    @(negedge i_clk);
    i_in_valid = 1'b1; i_in_data = 32'h4100_0000;
    @(posedge i_clk); #1 i_in_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("abort_x0", o_x0, 32'h0);
    check("abort_x1", o_x1, 32'h0);
    check("abort_out", {o_out_valid, o_start, o_busy, o_in_ready}, 4'b0001);
    check("abort_data", o_out_data, 32'h0);
    begin
      int s = 0, v = 0;
      for (int n = 0; n < 30; n++) begin
        @(negedge i_clk);
        s += int'(o_start);
        v += int'(o_out_valid);
      end
      check("abort_no_start", s, 0);
      check("abort_no_valid", v, 0);
    end

`ifdef BIQUAD_DRV_BYPASS_EN
    run(32'h40A0_0000, 1'b1, 0, 2, 0, 32'h40A0_0000);
    check("byp_x0", o_x0, 32'h40A0_0000);
    check("byp_x1", o_x1, 32'h0);
`endif

    run(32'h4080_0000, 1'b0, W + 1, W + 3, 0, 32'hC080_0000);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
